// File: rtl/pcla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package pcla_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int unsigned pcla_stages(input int unsigned width, input int unsigned block);
        return (width + block - 1) / block;
    endfunction

    function automatic int unsigned pcla_min(input int unsigned x, input int unsigned y);
        return (x < y) ? x : y;
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational N-bit carry-lookahead group: sum and group carry-out from bits and carry-in.
module cla_group
    import pcla_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    gp_t  [N-1:0] gp;
    logic [N:0]   c;

    // Every carry is a flat sum-of-products over the lower generate/propagate terms.
    always_comb begin
        gp = '0;
        c  = '0;
        for (int i = 0; i < N; i++) begin
            gp[i].g = a[i] & b[i];
            gp[i].p = a[i] ^ b[i];
        end
        c[0] = cin;
        for (int i = 0; i < N; i++) begin
            logic acc;
            logic prop;
            acc  = gp[i].g;
            prop = gp[i].p;
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prop & gp[j].g);
                prop = prop & gp[j].p;
            end
            c[i+1] = acc | (prop & cin);
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = gp[i].p ^ c[i];
        end
    end

    assign cout = c[N];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder, one BLOCK-bit lookahead group per stage, valid/ready with full-pipeline stall.
// Optional subtract mode (extra sub port) is enabled by defining PCLA_SUB_EN.
module pipelined_cla_adder
    import pcla_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PCLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = pcla_stages(WIDTH, BLOCK);

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign stall    = out_valid && !out_ready;
    assign in_ready = rst || !stall;

`ifdef PCLA_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // Stage k adds group k; upper operand bits ride along, finished sum bits accumulate below.
    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int unsigned LO = k * BLOCK;
        localparam int unsigned HI = pcla_min((k + 1) * BLOCK, WIDTH) - 1;
        localparam int unsigned GW = HI - LO + 1;
        localparam int unsigned RW = WIDTH - LO;

        logic [RW-1:0] a_rem;
        logic [RW-1:0] b_rem;
        logic          c_in;
        logic          v_in;
        logic [GW-1:0] s_grp;
        logic          c_grp;
        logic [HI:0]   s_next;

        if (k == 0) begin : g_src
            assign a_rem  = a;
            assign b_rem  = b_eff;
            assign c_in   = cin_eff;
            assign v_in   = in_valid;
            assign s_next = s_grp;
        end else begin : g_src
            assign a_rem  = stg[k-1].g_mid.a_q;
            assign b_rem  = stg[k-1].g_mid.b_q;
            assign c_in   = stg[k-1].g_mid.c_q;
            assign v_in   = stg[k-1].g_mid.v_q;
            assign s_next = {s_grp, stg[k-1].g_mid.s_q};
        end

        cla_group #(.N(GW)) u_grp (
            .a    (a_rem[GW-1:0]),
            .b    (b_rem[GW-1:0]),
            .cin  (c_in),
            .sum  (s_grp),
            .cout (c_grp)
        );

        if (k < STAGES - 1) begin : g_mid
            localparam int unsigned NW = RW - GW;

            logic [NW-1:0] a_q;
            logic [NW-1:0] b_q;
            logic [HI:0]   s_q;
            logic          c_q;
            logic          v_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                end else if (!stall) begin
                    v_q <= v_in;
                    a_q <= a_rem[RW-1:GW];
                    b_q <= b_rem[RW-1:GW];
                    s_q <= s_next;
                    c_q <= c_grp;
                end
            end
        end else begin : g_last
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                end else if (!stall) begin
                    out_valid <= v_in;
                    sum       <= s_next;
                    cout      <= c_grp;
                    ovf       <= (a_rem[GW-1] == b_rem[GW-1]) && (s_grp[GW-1] != a_rem[GW-1]);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder at WIDTH=10, BLOCK=4 (three stages).
module tb_pipelined_cla_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] a;
    logic [9:0] b;
    logic       cin;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] sum;
    logic       cout;
    logic       ovf;

    typedef struct {
        logic [9:0] s;
        logic       co;
        logic       ov;
        int         cyc;
        bit         lat;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;
    bit   lat_chk = 1'b0;

    pipelined_cla_adder #(.WIDTH(10), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PCLA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on every completed output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: got sum=%0d with no result pending", sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_chk++;
                if (sum !== e.s || cout !== e.co || ovf !== e.ov) begin
                    n_fail++;
                    $display("FAIL result: got sum=%0d cout=%0d ovf=%0d expected sum=%0d cout=%0d ovf=%0d",
                             sum, cout, ovf, e.s, e.co, e.ov);
                end
                if (e.lat) check("latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic send(input logic [9:0] ta, input logic [9:0] tb, input logic tc, input logic ts,
                        input logic [9:0] es, input logic eco, input logic eov);
        bit got;
        got      = 1'b0;
        a        = ta;
        b        = tb;
        cin      = tc;
        sub      = ts;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{s: es, co: eco, ov: eov, cyc: cyc + 3, lat: lat_chk});
                got = 1'b1;
            end
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && sb.size() > 0; n++) @(negedge clk);
        check("drain_pending", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_cout", int'(cout), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single beats with latency check, including carry/overflow corners
        lat_chk = 1'b1;
        send(10'd55, 10'd421, 1'b0, 1'b0, 10'd476, 1'b0, 1'b0);
        drain();
        send(10'd1023, 10'd1, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0);
        send(10'd511, 10'd1, 1'b0, 1'b0, 10'd512, 1'b0, 1'b1);
        send(10'd512, 10'd512, 1'b0, 1'b0, 10'd0, 1'b1, 1'b1);
        send(10'd0, 10'd0, 1'b1, 1'b0, 10'd1, 1'b0, 1'b0);
        send(10'd1023, 10'd1023, 1'b1, 1'b0, 10'd1023, 1'b1, 1'b0);
        drain();

        // Back-to-back stream at full throughput
        for (int i = 0; i < 8; i++)
            send(10'(i), 10'(2 * i), 1'b0, 1'b0, 10'(3 * i), 1'b0, 1'b0);
        drain();

        // Same stream with backpressure during cycles 4..7
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(10'(i), 10'(2 * i), 1'b0, 1'b0, 10'(3 * i), 1'b0, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    check("stall_in_ready", int'(in_ready), 0);
                    check("stall_sum_held", int'(sum), 3);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight
        send(10'd7, 10'd8, 1'b0, 1'b0, 10'd15, 1'b0, 1'b0);
        send(10'd9, 10'd10, 1'b0, 1'b0, 10'd19, 1'b0, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_out_valid", int'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        lat_chk = 1'b1;
        send(10'd100, 10'd200, 1'b0, 1'b0, 10'd300, 1'b0, 1'b0);
        drain();

`ifdef PCLA_SUB_EN
        send(10'd421, 10'd55, 1'b0, 1'b1, 10'd366, 1'b1, 1'b0);
        send(10'd55, 10'd421, 1'b1, 1'b1, 10'd658, 1'b0, 1'b0);
        send(10'd55, 10'd421, 1'b0, 1'b0, 10'd476, 1'b0, 1'b0);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
